// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Front-end fetch stage. Holds the PC and issues one word read
//               at a time to instruction memory. It buffers one fetched
//               instruction, together with its PC and PC+4, for decode.
//               Taken-branch redirects from execute replace the PC, and any
//               fetch already in flight on the wrong path is squashed.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC        PC loaded on reset (bits [1:0] must be 0)
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   redirect_valid  taken branch from execute; load redirect_addr as new PC
//   redirect_addr   branch target (bits [1:0] forced to 0, misalignment flagged)
//   imem_req        memory request valid
//   imem_addr       memory request word address
//   imem_ready      memory accepts request when imem_req && imem_ready
//   imem_rvalid     read data valid, one pulse per accepted request
//   imem_rdata      fetched instruction word
//   instr_valid     buffered instruction available to decode
//   instr_ready     decode consumes when instr_valid && instr_ready
//   instr_data      buffered instruction word
//   instr_pc        address of instr_data
//   instr_pc4       instr_pc + 4 (wraps at 2^32)
//   misalign_err    one-cycle pulse when redirect_addr[1:0] != 0
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inflight;
  logic        squash;

  logic [31:0] redirect_pc;
  logic [31:0] inflight_pc4;
  logic        accept;

  assign redirect_pc  = {redirect_addr[31:2], 2'b00};
  assign inflight_pc4 = pc_inflight + 32'd4;
  // imem_req is only ever high in ISSUE, so this is the ISSUE handshake.
  assign accept       = imem_req & imem_ready;
  // The PC register drives the request address directly. It changes only on
  // a redirect or on a returned fetch, so it stays stable while a request
  // waits for acceptance.
  assign imem_addr    = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ISSUE;
      pc           <= RESET_PC;
      pc_inflight  <= RESET_PC;
      squash       <= 1'b0;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      instr_data   <= 32'd0;
      instr_pc     <= 32'd0;
      instr_pc4    <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid & (|redirect_addr[1:0]);

      // Redirect wins over everything. The state-specific branches below only
      // override pc when no redirect is present.
      if (redirect_valid) begin
        pc <= redirect_pc;
      end

      case (state)
        ST_ISSUE: begin
          if (accept) begin
            pc_inflight <= pc;
            imem_req    <= 1'b0;
            state       <= ST_WAIT;
            // The request just accepted targets the old PC. If a redirect
            // arrived in the same cycle, its response must be dropped.
            squash      <= redirect_valid;
          end else begin
            // Covers the first cycle after reset and holds the request high
            // until the memory accepts it.
            imem_req <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (imem_rvalid) begin
            if (squash || redirect_valid) begin
              // Wrong-path response: discard it and refetch from the new PC.
              squash   <= 1'b0;
              imem_req <= 1'b1;
              state    <= ST_ISSUE;
            end else begin
              instr_data  <= imem_rdata;
              instr_pc    <= pc_inflight;
              instr_pc4   <= inflight_pc4;
              pc          <= inflight_pc4;
              instr_valid <= 1'b1;
              state       <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            // One response is still owed. It must be swallowed when it comes.
            squash <= 1'b1;
          end
        end

        ST_HOLD: begin
          // A redirect drops the buffered instruction even if decode takes
          // it in the same cycle. Either way, fetch resumes from pc.
          if (redirect_valid || instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= ST_ISSUE;
          end
        end

        default: begin
          instr_valid <= 1'b0;
          squash      <= 1'b0;
          imem_req    <= 1'b1;
          state       <= ST_ISSUE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch. The
//               instruction memory is driven by hand, cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_pc4      (instr_pc4),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in ISSUE with the request up: accept, return data with zero
  // wait, then check the buffered instruction. Ends in HOLD.
  task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, ".req"},  {31'd0, imem_req}, 32'd1);
    chk({tag, ".addr"}, imem_addr, addr);
    imem_ready = 1'b1;
    tick();
    chk({tag, ".req_wait"}, {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".data"},  instr_data, data);
    chk({tag, ".pc"},    instr_pc, addr);
    chk({tag, ".pc4"},   instr_pc4, addr + 32'd4);
  endtask

  // Decode takes the buffered instruction. The next request must appear at once.
  task automatic consume(input string tag, input logic [31:0] next_addr);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk({tag, ".valid_drop"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, ".req"},        {31'd0, imem_req}, 32'd1);
    chk({tag, ".next_addr"},  imem_addr, next_addr);
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    instr_ready    = 1'b0;

    // ---- reset state
    tick();
    tick();
    chk("rst.req",   {31'd0, imem_req}, 32'd0);
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.mis",   {31'd0, misalign_err}, 32'd0);
    chk("rst.data",  instr_data, 32'd0);
    chk("rst.pc",    instr_pc, 32'd0);
    chk("rst.pc4",   instr_pc4, 32'd0);
    chk("rst.addr",  imem_addr, 32'h100);
    rst_n = 1'b1;
    tick();
    chk("post_rst.req", {31'd0, imem_req}, 32'd1);

    // ---- sequential fetch 0x100, 0x104, 0x108
    fetch_one("f100", 32'h100, 32'h1111_0001);
    consume("c100", 32'h104);
    fetch_one("f104", 32'h104, 32'h2222_0002);
    consume("c104", 32'h108);
    fetch_one("f108", 32'h108, 32'h3333_0003);

    // ---- decode stalls for 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall.valid", {31'd0, instr_valid}, 32'd1);
      chk("stall.data",  instr_data, 32'h3333_0003);
      chk("stall.pc",    instr_pc, 32'h108);
      chk("stall.req",   {31'd0, imem_req}, 32'd0);
    end
    consume("c108", 32'h10C);

    // ---- redirect in ISSUE, not accepted: new address next cycle
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h104;
    tick();
    redirect_valid = 1'b0;
    chk("rdi.addr", imem_addr, 32'h104);
    chk("rdi.req",  {31'd0, imem_req}, 32'd1);
    chk("rdi.mis",  {31'd0, misalign_err}, 32'd0);
    tick();
    chk("rdi.hold_addr", imem_addr, 32'h104);
    chk("rdi.hold_req",  {31'd0, imem_req}, 32'd1);

    // ---- fetch 0x104 is accepted, then redirected to 0x2000 while in WAIT
    imem_ready = 1'b1;
    tick();
    chk("sq.req_wait", {31'd0, imem_req}, 32'd0);
    tick();
    chk("sq.still_wait", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h2000;
    tick();
    redirect_valid = 1'b0;
    chk("sq.req_after_rd", {31'd0, imem_req}, 32'd0);
    chk("sq.valid_after_rd", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("sq.valid", {31'd0, instr_valid}, 32'd0);
    chk("sq.data",  instr_data, 32'h3333_0003);
    chk("sq.req",   {31'd0, imem_req}, 32'd1);
    chk("sq.addr",  imem_addr, 32'h2000);
    tick();
    chk("sq.never_valid", {31'd0, instr_valid}, 32'd0);

    // ---- redirect in HOLD with instr_ready=1 in the same cycle.
    // The extra tick above was an accepted request at 0x2000, so answer it here.
    chk("f2000.req_wait", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h4444_0004;
    tick();
    imem_rvalid = 1'b0;
    chk("f2000.valid", {31'd0, instr_valid}, 32'd1);
    chk("f2000.pc",    instr_pc, 32'h2000);
    chk("f2000.data",  instr_data, 32'h4444_0004);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h3000;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    chk("rdh.valid", {31'd0, instr_valid}, 32'd0);
    chk("rdh.req",   {31'd0, imem_req}, 32'd1);
    chk("rdh.addr",  imem_addr, 32'h3000);

    // ---- misaligned redirect
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_4002;
    tick();
    redirect_valid = 1'b0;
    chk("mis.pulse", {31'd0, misalign_err}, 32'd1);
    chk("mis.addr",  imem_addr, 32'h4000);
    tick();
    chk("mis.clear", {31'd0, misalign_err}, 32'd0);
    chk("mis.addr2", imem_addr, 32'h4000);

    // ---- PC+4 wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch_one("fwrap", 32'hFFFF_FFFC, 32'h5555_0005);
    chk("wrap.pc4", instr_pc4, 32'h0);
    consume("cwrap", 32'h0);

    // ---- accept the fetch at 0, then reset during WAIT
    imem_ready = 1'b1;
    tick();
    chk("prerst.req", {31'd0, imem_req}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.req",   {31'd0, imem_req}, 32'd0);
    chk("arst.valid", {31'd0, instr_valid}, 32'd0);
    chk("arst.mis",   {31'd0, misalign_err}, 32'd0);
    chk("arst.data",  instr_data, 32'd0);
    chk("arst.pc",    instr_pc, 32'd0);
    chk("arst.pc4",   instr_pc4, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2.req",  {31'd0, imem_req}, 32'd1);
    chk("rst2.addr", imem_addr, 32'h100);

    // ---- redirect in the same cycle the old request is accepted, then a
    // second redirect while the squash is still pending
    imem_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h5000;
    tick();
    redirect_valid = 1'b0;
    chk("sqa.req",  {31'd0, imem_req}, 32'd0);
    chk("sqa.addr", imem_addr, 32'h5000);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h6000;
    tick();
    redirect_valid = 1'b0;
    chk("sqa.req2", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    chk("sqa.valid", {31'd0, instr_valid}, 32'd0);
    chk("sqa.data",  instr_data, 32'd0);
    fetch_one("f6000", 32'h6000, 32'h6666_0006);
    consume("c6000", 32'h6004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
